// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID/EX stage.
//   ALU_*      : 3-bit ALU operation codes (ALU_NOP doubles as the bubble opcode)
//   fwd_sel_e  : operand source selected by the forwarding mux
package cpu_pkg;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding mux for one source register.
//   rs_addr_i / rs_data_i          : registered source index and register-file data
//   exmem_* / memwb_*              : in-flight writeback candidates
//   data_o                         : resolved operand value
//   sel_o                          : chosen source (fwd_sel_e encoding)
// EX/MEM is the younger result and wins over MEM/WB; x0 is never forwarded.
module forward_mux
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]    rs_data_i,
    input  logic               exmem_regwrite_i,
    input  logic [RADDR_W-1:0] exmem_rdaddr_i,
    input  logic [XLEN-1:0]    exmem_data_i,
    input  logic               memwb_regwrite_i,
    input  logic [RADDR_W-1:0] memwb_rdaddr_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic [XLEN-1:0]    data_o,
    output logic [1:0]         sel_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (exmem_regwrite_i && (exmem_rdaddr_i != '0) && (exmem_rdaddr_i == rs_addr_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite_i && (memwb_rdaddr_i != '0) && (memwb_rdaddr_i == rs_addr_i)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data_o = rs_data_i;
        case (sel)
            FWD_EXMEM: data_o = exmem_data_i;
            FWD_MEMWB: data_o = memwb_data_i;
            default:   data_o = rs_data_i;
        endcase
    end

    assign sel_o = sel;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding in front of the ALU.
//   clk_i, rst_i (async, active-high)
//   valid_i, stall_i, flush_i       : pipeline control (flush > stall > load)
//   RS1/RS2/RD addr, RS1/RS2 data,
//   imm_i, ALUSrc_i, ALUCtrl_i,
//   RegWrite_i                      : decoded instruction from ID
//   EXMEM_* / MEMWB_*               : forwarding sources
//   data1_o, data2_o, ALUCtrl_o     : ALU operands and opcode
//   RDaddr_o, RegWrite_o, valid_o   : registered, passed on to EX/MEM
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [RADDR_W-1:0] RS1addr_i,
    input  logic [RADDR_W-1:0] RS2addr_i,
    input  logic [RADDR_W-1:0] RDaddr_i,
    input  logic [XLEN-1:0]    RS1data_i,
    input  logic [XLEN-1:0]    RS2data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic               ALUSrc_i,
    input  logic [2:0]         ALUCtrl_i,
    input  logic               RegWrite_i,
    input  logic               EXMEM_RegWrite_i,
    input  logic [RADDR_W-1:0] EXMEM_RDaddr_i,
    input  logic [XLEN-1:0]    EXMEM_data_i,
    input  logic               MEMWB_RegWrite_i,
    input  logic [RADDR_W-1:0] MEMWB_RDaddr_i,
    input  logic [XLEN-1:0]    MEMWB_data_i,
    output logic [XLEN-1:0]    data1_o,
    output logic [XLEN-1:0]    data2_o,
    output logic [2:0]         ALUCtrl_o,
    output logic [RADDR_W-1:0] RDaddr_o,
    output logic               RegWrite_o,
    output logic               valid_o
);

    logic               valid_q,    valid_d;
    logic [RADDR_W-1:0] rs1addr_q,  rs1addr_d;
    logic [RADDR_W-1:0] rs2addr_q,  rs2addr_d;
    logic [RADDR_W-1:0] rdaddr_q,   rdaddr_d;
    logic [XLEN-1:0]    rs1data_q,  rs1data_d;
    logic [XLEN-1:0]    rs2data_q,  rs2data_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic               alusrc_q,   alusrc_d;
    logic [2:0]         aluctrl_q,  aluctrl_d;
    logic               regwrite_q, regwrite_d;

    logic               bubble;
    logic               memwb_hit_rs1;
    logic               memwb_hit_rs2;

    // A bubble is loaded on flush, or on a normal load with no valid instruction.
    assign bubble = flush_i || (!stall_i && !valid_i);

    // Writeback retiring while we hold: refresh the held operand so it is not stale
    // once MEM/WB moves on.
    assign memwb_hit_rs1 = MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs1addr_q);
    assign memwb_hit_rs2 = MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs2addr_q);

    always_comb begin
        valid_d    = valid_q;
        rs1addr_d  = rs1addr_q;
        rs2addr_d  = rs2addr_q;
        rdaddr_d   = rdaddr_q;
        rs1data_d  = rs1data_q;
        rs2data_d  = rs2data_q;
        imm_d      = imm_q;
        alusrc_d   = alusrc_q;
        aluctrl_d  = aluctrl_q;
        regwrite_d = regwrite_q;

        if (bubble) begin
            valid_d    = 1'b0;
            rs1addr_d  = '0;
            rs2addr_d  = '0;
            rdaddr_d   = '0;
            rs1data_d  = '0;
            rs2data_d  = '0;
            imm_d      = '0;
            alusrc_d   = 1'b0;
            aluctrl_d  = ALU_NOP;
            regwrite_d = 1'b0;
        end else if (stall_i) begin
            if (memwb_hit_rs1) begin
                rs1data_d = MEMWB_data_i;
            end
            if (memwb_hit_rs2) begin
                rs2data_d = MEMWB_data_i;
            end
        end else begin
            valid_d    = 1'b1;
            rs1addr_d  = RS1addr_i;
            rs2addr_d  = RS2addr_i;
            rdaddr_d   = RDaddr_i;
            rs1data_d  = RS1data_i;
            rs2data_d  = RS2data_i;
            imm_d      = imm_i;
            alusrc_d   = ALUSrc_i;
            aluctrl_d  = ALUCtrl_i;
            regwrite_d = RegWrite_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            rs1addr_q  <= '0;
            rs2addr_q  <= '0;
            rdaddr_q   <= '0;
            rs1data_q  <= '0;
            rs2data_q  <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= ALU_NOP;
            regwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1addr_q  <= rs1addr_d;
            rs2addr_q  <= rs2addr_d;
            rdaddr_q   <= rdaddr_d;
            rs1data_q  <= rs1data_d;
            rs2data_q  <= rs2data_d;
            imm_q      <= imm_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            regwrite_q <= regwrite_d;
        end
    end

    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
    logic [1:0]      fwd1_sel;
    logic [1:0]      fwd2_sel;

    forward_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs1 (
        .rs_addr_i        (rs1addr_q),
        .rs_data_i        (rs1data_q),
        .exmem_regwrite_i (EXMEM_RegWrite_i),
        .exmem_rdaddr_i   (EXMEM_RDaddr_i),
        .exmem_data_i     (EXMEM_data_i),
        .memwb_regwrite_i (MEMWB_RegWrite_i),
        .memwb_rdaddr_i   (MEMWB_RDaddr_i),
        .memwb_data_i     (MEMWB_data_i),
        .data_o           (fwd1_data),
        .sel_o            (fwd1_sel)
    );

    forward_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs2 (
        .rs_addr_i        (rs2addr_q),
        .rs_data_i        (rs2data_q),
        .exmem_regwrite_i (EXMEM_RegWrite_i),
        .exmem_rdaddr_i   (EXMEM_RDaddr_i),
        .exmem_data_i     (EXMEM_data_i),
        .memwb_regwrite_i (MEMWB_RegWrite_i),
        .memwb_rdaddr_i   (MEMWB_RDaddr_i),
        .memwb_data_i     (MEMWB_data_i),
        .data_o           (fwd2_data),
        .sel_o            (fwd2_sel)
    );

    // Sanity: a forwarding select never points at a source targeting x0.
    always_comb begin
        if (!rst_i) begin
            assert (!((fwd1_sel == FWD_EXMEM) && (EXMEM_RDaddr_i == '0)));
            assert (!((fwd2_sel == FWD_MEMWB) && (MEMWB_RDaddr_i == '0)));
        end
    end

    assign data1_o    = fwd1_data;
    assign data2_o    = alusrc_q ? imm_q : fwd2_data;
    assign ALUCtrl_o  = valid_q ? aluctrl_q : ALU_NOP;
    assign RDaddr_o   = rdaddr_q;
    assign RegWrite_o = regwrite_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, stall_i, flush_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
    logic [31:0] RS1data_i, RS2data_i, imm_i;
    logic        ALUSrc_i;
    logic [2:0]  ALUCtrl_i;
    logic        RegWrite_i;
    logic        EXMEM_RegWrite_i;
    logic [4:0]  EXMEM_RDaddr_i;
    logic [31:0] EXMEM_data_i;
    logic        MEMWB_RegWrite_i;
    logic [4:0]  MEMWB_RDaddr_i;
    logic [31:0] MEMWB_data_i;
    logic [31:0] data1_o, data2_o;
    logic [2:0]  ALUCtrl_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o, valid_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: the instruction currently held by the stage.
    logic        m_valid;
    logic [4:0]  m_rs1a, m_rs2a, m_rda;
    logic [31:0] m_rs1d, m_rs2d, m_imm;
    logic        m_alusrc;
    logic [2:0]  m_alu;
    logic        m_rw;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(
        .XLEN    (32),
        .RADDR_W (5)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .RS1addr_i        (RS1addr_i),
        .RS2addr_i        (RS2addr_i),
        .RDaddr_i         (RDaddr_i),
        .RS1data_i        (RS1data_i),
        .RS2data_i        (RS2data_i),
        .imm_i            (imm_i),
        .ALUSrc_i         (ALUSrc_i),
        .ALUCtrl_i        (ALUCtrl_i),
        .RegWrite_i       (RegWrite_i),
        .EXMEM_RegWrite_i (EXMEM_RegWrite_i),
        .EXMEM_RDaddr_i   (EXMEM_RDaddr_i),
        .EXMEM_data_i     (EXMEM_data_i),
        .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
        .MEMWB_RDaddr_i   (MEMWB_RDaddr_i),
        .MEMWB_data_i     (MEMWB_data_i),
        .data1_o          (data1_o),
        .data2_o          (data2_o),
        .ALUCtrl_o        (ALUCtrl_o),
        .RDaddr_o         (RDaddr_o),
        .RegWrite_o       (RegWrite_o),
        .valid_o          (valid_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int src_of(input logic [4:0] a);
        if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 0 && EXMEM_RDaddr_i == a) return 1;
        if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 0 && MEMWB_RDaddr_i == a) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] a, input logic [31:0] held);
        case (src_of(a))
            1:       return EXMEM_data_i;
            2:       return MEMWB_data_i;
            default: return held;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rs1a = 0; m_rs2a = 0; m_rda = 0;
        m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_alusrc = 0; m_alu = 0; m_rw = 0;
    endtask

    // Applied at the clock edge using the inputs that were held across it.
    task automatic model_edge();
        if (flush_i) begin
            model_clear();
        end else if (stall_i) begin
            if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 0) begin
                if (MEMWB_RDaddr_i == m_rs1a) m_rs1d = MEMWB_data_i;
                if (MEMWB_RDaddr_i == m_rs2a) m_rs2d = MEMWB_data_i;
            end
        end else if (!valid_i) begin
            model_clear();
        end else begin
            m_valid = 1; m_rs1a = RS1addr_i; m_rs2a = RS2addr_i; m_rda = RDaddr_i;
            m_rs1d = RS1data_i; m_rs2d = RS2data_i; m_imm = imm_i;
            m_alusrc = ALUSrc_i; m_alu = ALUCtrl_i; m_rw = RegWrite_i;
        end
    endtask

    task automatic check_all();
        check("data1", data1_o, value_of(m_rs1a, m_rs1d));
        check("data2", data2_o, m_alusrc ? m_imm : value_of(m_rs2a, m_rs2d));
        check("aluctrl", {29'd0, ALUCtrl_o}, m_valid ? {29'd0, m_alu} : 32'd0);
        check("rdaddr", {27'd0, RDaddr_o}, {27'd0, m_rda});
        check("regwrite", {31'd0, RegWrite_o}, {31'd0, m_rw});
        check("valid", {31'd0, valid_o}, {31'd0, m_valid});
        check("sel1", {30'd0, dut.u_fwd_rs1.sel_o}, src_of(m_rs1a));
        check("sel2", {30'd0, dut.u_fwd_rs2.sel_o}, src_of(m_rs2a));
    endtask

    // Inputs are driven before calling; checks settle, then the edge is taken.
    task automatic step();
        #1;
        check_all();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic clr_inputs();
        valid_i = 0; stall_i = 0; flush_i = 0;
        RS1addr_i = 0; RS2addr_i = 0; RDaddr_i = 0;
        RS1data_i = 0; RS2data_i = 0; imm_i = 0;
        ALUSrc_i = 0; ALUCtrl_i = 0; RegWrite_i = 0;
        EXMEM_RegWrite_i = 0; EXMEM_RDaddr_i = 0; EXMEM_data_i = 0;
        MEMWB_RegWrite_i = 0; MEMWB_RDaddr_i = 0; MEMWB_data_i = 0;
    endtask

    task automatic load_instr(input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic src, input logic [31:0] im, input logic [2:0] op);
        clr_inputs();
        valid_i = 1; RS1addr_i = a1; RS1data_i = d1; RS2addr_i = a2; RS2data_i = d2;
        ALUSrc_i = src; imm_i = im; ALUCtrl_i = op; RDaddr_i = 5'd9; RegWrite_i = 1;
        step();
    endtask

    task automatic async_reset();
        rst_i = 1;
        #1;
        model_clear();
        check("rst_data1", data1_o, 32'd0);
        check("rst_data2", data2_o, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_alu", {29'd0, ALUCtrl_o}, 32'd0);
        rst_i = 0;
    endtask

    initial begin
        rst_i = 1;
        clr_inputs();
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        check("reset_rd", {27'd0, RDaddr_o}, 32'd0);
        rst_i = 0;

        // Basic load
        load_instr(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 3'b001);
        clr_inputs();
        #1;
        check("load_d1", data1_o, 32'd5);
        check("load_d2", data2_o, 32'd7);
        check("load_alu", {29'd0, ALUCtrl_o}, 32'd1);
        check("load_valid", {31'd0, valid_o}, 32'd1);
        step();

        // EX/MEM beats MEM/WB on rs1
        load_instr(5'd3, 32'h11, 5'd4, 32'h22, 1'b0, 32'd0, 3'b010);
        clr_inputs();
        EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 5'd3; EXMEM_data_i = 32'hAA;
        MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 5'd3; MEMWB_data_i = 32'hBB;
        #1;
        check("fwd_prio", data1_o, 32'hAA);
        step();

        // x0 never forwarded
        load_instr(5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 32'd0, 3'b100);
        clr_inputs();
        EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 5'd0; EXMEM_data_i = 32'hAA;
        MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 5'd0; MEMWB_data_i = 32'hBB;
        #1;
        check("fwd_x0", data1_o, 32'h55);
        step();

        // Immediate overrides a forwarding hit on rs2
        load_instr(5'd1, 32'd1, 5'd6, 32'd2, 1'b1, 32'hFFFF_FFF0, 3'b001);
        clr_inputs();
        EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 5'd6; EXMEM_data_i = 32'hDEAD;
        #1;
        check("imm_sel", data2_o, 32'hFFFF_FFF0);
        step();

        // Stall for three cycles; writeback to held rs2 in the second
        load_instr(5'd1, 32'h10, 5'd4, 32'h99, 1'b0, 32'd0, 3'b101);
        clr_inputs(); stall_i = 1;
        step();
        MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 5'd4; MEMWB_data_i = 32'h1234;
        step();
        MEMWB_RegWrite_i = 0; MEMWB_data_i = 32'h0;
        step();
        #1;
        check("stall_refresh", data2_o, 32'h1234);
        check("stall_valid", {31'd0, valid_o}, 32'd1);
        stall_i = 0; valid_i = 0;
        step();

        // Flush and stall together produce a bubble
        load_instr(5'd2, 32'h3, 5'd3, 32'h4, 1'b0, 32'd0, 3'b011);
        clr_inputs(); flush_i = 1; stall_i = 1; valid_i = 1; RegWrite_i = 1; ALUCtrl_i = 3'b111;
        step();
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_rw", {31'd0, RegWrite_o}, 32'd0);
        check("flush_alu", {29'd0, ALUCtrl_o}, 32'd0);

        // Reset mid-stall, then load on the next edge
        load_instr(5'd2, 32'h77, 5'd3, 32'h88, 1'b0, 32'd0, 3'b110);
        clr_inputs(); stall_i = 1;
        async_reset();
        stall_i = 0; valid_i = 1; RS1addr_i = 5'd1; RS1data_i = 32'h4242; ALUCtrl_i = 3'b001;
        step();
        check("post_rst_load", data1_o, 32'h4242);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) async_reset();
            valid_i          = ($urandom_range(0, 9) < 8);
            stall_i          = ($urandom_range(0, 3) == 0);
            flush_i          = ($urandom_range(0, 9) == 0);
            RS1addr_i        = 5'($urandom_range(0, 3));
            RS2addr_i        = 5'($urandom_range(0, 3));
            RDaddr_i         = 5'($urandom_range(0, 31));
            RS1data_i        = $urandom;
            RS2data_i        = $urandom;
            imm_i            = $urandom;
            ALUSrc_i         = 1'($urandom_range(0, 1));
            ALUCtrl_i        = 3'($urandom_range(0, 7));
            RegWrite_i       = 1'($urandom_range(0, 1));
            EXMEM_RegWrite_i = 1'($urandom_range(0, 1));
            EXMEM_RDaddr_i   = 5'($urandom_range(0, 3));
            EXMEM_data_i     = $urandom;
            MEMWB_RegWrite_i = 1'($urandom_range(0, 1));
            MEMWB_RDaddr_i   = 5'($urandom_range(0, 3));
            MEMWB_data_i     = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
